// File: rtl/mux_pkg.sv
// Shared helpers for the word multiplexer slice.
package mux_pkg;

    // Select width for an N-input mux; a single input still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_onehot_dec.sv
// Select decoder: turns a binary word select into a one-hot vector and a
// range-valid flag. Out-of-range selects give an all-zero vector.
module mux_onehot_dec
    import mux_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = sel_width(N_INPUTS)
) (
    input  logic [SEL_W-1:0]    sel_i,
    output logic [N_INPUTS-1:0] onehot_o,
    output logic                valid_o
);

    // Decode each input position; validity is simply "some position matched".
    always_comb begin
        onehot_o = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            onehot_o[k] = (sel_i == SEL_W'(k));
        end
        valid_o = |onehot_o;
    end

endmodule

// File: rtl/mux.sv
// Parameterised N-input word multiplexer with a combinational output, a
// one-hot select decode and a registered copy of the selected word and its
// valid flag.
module mux
    import mux_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               N_INPUTS = 4,
    parameter logic [WIDTH-1:0] OOR_VAL  = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_INPUTS*WIDTH-1:0]   data_i,
    input  logic [sel_width(N_INPUTS)-1:0] sel_i,
    output logic [WIDTH-1:0]            data_o,
    output logic                        sel_valid_o,
    output logic [N_INPUTS-1:0]         onehot_o,
    output logic [WIDTH-1:0]            data_q_o,
    output logic                        valid_q_o
);

    localparam int SEL_W = sel_width(N_INPUTS);

    generate
        if (WIDTH < 1 || N_INPUTS < 1) begin : g_param_check
            $error("mux: WIDTH and N_INPUTS must both be at least 1");
        end
    endgenerate

    logic [N_INPUTS-1:0] onehot_p0;
    logic                vld_p0;
    logic [WIDTH-1:0]    data_p0;
    logic [WIDTH-1:0]    data_p1;
    logic                vld_p1;

    mux_onehot_dec #(
        .N_INPUTS (N_INPUTS),
        .SEL_W    (SEL_W)
    ) u_dec (
        .sel_i    (sel_i),
        .onehot_o (onehot_p0),
        .valid_o  (vld_p0)
    );

    // AND-OR word select driven by the one-hot decode; out-of-range selects
    // leave every term zero, so the fallback value seeds the accumulator.
    always_comb begin
        data_p0 = vld_p0 ? '0 : OOR_VAL;
        for (int k = 0; k < N_INPUTS; k++) begin
            data_p0 = data_p0 | ({WIDTH{onehot_p0[k]}} & data_i[k*WIDTH +: WIDTH]);
        end
    end

    assign data_o      = data_p0;
    assign sel_valid_o = vld_p0;
    assign onehot_o    = onehot_p0;

    // Stage p0 -> p1: capture the selected word and its valid flag; an
    // asynchronous reset discards whatever had been captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            data_p1 <= data_p0;
            vld_p1  <= vld_p0;
        end
    end

    assign data_q_o  = data_p1;
    assign valid_q_o = vld_p1;

endmodule

// File: tb/tb_mux.sv
// Randomised bench for the word multiplexer: three configurations (4 inputs,
// 3 inputs with an out-of-range value, 1 input) share clock and reset and are
// compared against a behavioural model kept here.
module tb_mux;

    logic clk_i = 1'b0;
    logic clk_run = 1'b0;
    logic rst_ni;

    // Clock stays idle until clk_run is raised.
    always begin
        #5;
        if (clk_run) clk_i = ~clk_i;
    end

    logic [7:0] w4 [4];
    logic [7:0] w3 [3];
    logic [7:0] w1;
    logic [1:0] sel4, sel3;
    logic [0:0] sel1;

    logic [31:0] data4;
    logic [23:0] data3;
    logic [7:0]  data1;
    assign data4 = {w4[3], w4[2], w4[1], w4[0]};
    assign data3 = {w3[2], w3[1], w3[0]};
    assign data1 = w1;

    logic [7:0] do4, do3, do1, dq4, dq3, dq1;
    logic       sv4, sv3, sv1, vq4, vq3, vq1;
    logic [3:0] oh4;
    logic [2:0] oh3;
    logic [0:0] oh1;

    mux #(.WIDTH(8), .N_INPUTS(4), .OOR_VAL(8'h00)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data4), .sel_i(sel4),
        .data_o(do4), .sel_valid_o(sv4), .onehot_o(oh4),
        .data_q_o(dq4), .valid_q_o(vq4));

    mux #(.WIDTH(8), .N_INPUTS(3), .OOR_VAL(8'hEE)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data3), .sel_i(sel3),
        .data_o(do3), .sel_valid_o(sv3), .onehot_o(oh3),
        .data_q_o(dq3), .valid_q_o(vq3));

    mux #(.WIDTH(8), .N_INPUTS(1), .OOR_VAL(8'h3C)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data1), .sel_i(sel1),
        .data_o(do1), .sel_valid_o(sv1), .onehot_o(oh1),
        .data_q_o(dq1), .valid_q_o(vq1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model expectations, derived directly from the selection rules.
    logic [7:0] e4, e3, e1;
    logic       ev4, ev3, ev1;
    logic [3:0] eoh4;
    logic [2:0] eoh3;
    logic [0:0] eoh1;
    logic [7:0] eq4, eq3, eq1;
    logic       evq4, evq3, evq1;

    task automatic model_comb();
        ev4  = (int'(sel4) < 4);
        e4   = w4[sel4];
        eoh4 = 4'(1 << sel4);
        ev3  = (int'(sel3) < 3);
        e3   = 8'hEE;
        eoh3 = 3'b000;
        if (ev3) begin
            e3   = w3[sel3];
            eoh3 = 3'(1 << sel3);
        end
        ev1  = (sel1 == 1'b0);
        e1   = ev1 ? w1 : 8'h3C;
        eoh1 = ev1 ? 1'b1 : 1'b0;
    endtask

    task automatic check_comb(input string t);
        model_comb();
        check({t, " data4"},   32'(do4),  32'(e4));
        check({t, " valid4"},  32'(sv4),  32'(ev4));
        check({t, " onehot4"}, 32'(oh4),  32'(eoh4));
        check({t, " data3"},   32'(do3),  32'(e3));
        check({t, " valid3"},  32'(sv3),  32'(ev3));
        check({t, " onehot3"}, 32'(oh3),  32'(eoh3));
        check({t, " data1"},   32'(do1),  32'(e1));
        check({t, " valid1"},  32'(sv1),  32'(ev1));
        check({t, " onehot1"}, 32'(oh1),  32'(eoh1));
    endtask

    task automatic check_reg(input string t);
        check({t, " q4"},  32'(dq4), 32'(eq4));
        check({t, " vq4"}, 32'(vq4), 32'(evq4));
        check({t, " q3"},  32'(dq3), 32'(eq3));
        check({t, " vq3"}, 32'(vq3), 32'(evq3));
        check({t, " q1"},  32'(dq1), 32'(eq1));
        check({t, " vq1"}, 32'(vq1), 32'(evq1));
    endtask

    task automatic clear_q();
        eq4 = 8'h00; eq3 = 8'h00; eq1 = 8'h00;
        evq4 = 1'b0; evq3 = 1'b0; evq1 = 1'b0;
    endtask

    task automatic capture_q();
        model_comb();
        eq4 = e4; eq3 = e3; eq1 = e1;
        evq4 = ev4; evq3 = ev3; evq1 = ev1;
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_oh;
        logic [7:0] base [4];
        base[0] = 8'hAA; base[1] = 8'hBB; base[2] = 8'hCC; base[3] = 8'hDD;

        // Reset held, clock idle.
        rst_ni = 1'b0;
        for (int k = 0; k < 4; k++) w4[k] = base[k];
        w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33;
        w1 = 8'h77;
        sel4 = 2'd0; sel3 = 2'd0; sel1 = 1'b0;
        #10;
        clear_q();
        check_reg("reset");

        // Baseline sweep against fixed constants.
        for (int s = 0; s < 4; s++) begin
            sel4 = 2'(s);
            #10;
            exp_oh = 4'(1 << s);
            check("sweep data4", 32'(do4), 32'(base[s]));
            check("sweep valid4", 32'(sv4), 32'd1);
            check("sweep onehot4", 32'(oh4), 32'(exp_oh));
        end

        // Data change under a fixed select, no clock.
        sel4 = 2'd2;
        w4[2] = 8'h5A;
        #1;
        check("datachg data4", 32'(do4), 32'h5A);

        // Out of range and degenerate configurations.
        sel3 = 2'd3;
        #1;
        check("oor data3", 32'(do3), 32'hEE);
        check("oor valid3", 32'(sv3), 32'd0);
        check("oor onehot3", 32'(oh3), 32'd0);
        sel1 = 1'b0;
        #1;
        check("deg sel0 data1", 32'(do1), 32'h77);
        check("deg sel0 onehot1", 32'(oh1), 32'd1);
        sel1 = 1'b1;
        #1;
        check("deg sel1 data1", 32'(do1), 32'h3C);
        check("deg sel1 onehot1", 32'(oh1), 32'd0);
        check_comb("static");
        check_reg("static");

        // Registered path: release reset between edges.
        clk_run = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        sel4 = 2'd1;
        sel3 = 2'd3;
        @(posedge clk_i);
        #1;
        check("reg q4 first", 32'(dq4), 32'hBB);
        check("reg vq4 first", 32'(vq4), 32'd1);
        check("reg oor q3", 32'(dq3), 32'hEE);
        check("reg oor vq3", 32'(vq3), 32'd0);
        check("reg oor q1", 32'(dq1), 32'h3C);
        sel4 = 2'd3;
        #1;
        check("reg q4 hold", 32'(dq4), 32'hBB);
        @(posedge clk_i);
        #1;
        check("reg q4 next", 32'(dq4), 32'hDD);

        // Asynchronous reset between edges.
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async q4", 32'(dq4), 32'h00);
        check("async vq4", 32'(vq4), 32'd0);
        sel4 = 2'd0;
        #1;
        check("async data4", 32'(do4), 32'hAA);
        @(posedge clk_i);
        #1;
        clear_q();
        check_reg("held reset");

        // Randomised phase: new inputs after each falling edge, occasional
        // asynchronous reset pulses, register checked after each rising edge.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            for (int k = 0; k < 4; k++) w4[k] = 8'($urandom);
            for (int k = 0; k < 3; k++) w3[k] = 8'($urandom);
            w1 = 8'($urandom);
            sel4 = 2'($urandom);
            sel3 = 2'($urandom);
            sel1 = 1'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rst_ni = 1'b0;
                #1;
                clear_q();
                check_reg("rand reset");
                #1;
            end
            rst_ni = 1'b1;
            #1;
            check_comb("rand");
            @(posedge clk_i);
            capture_q();
            #1;
            check_reg("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
